// File: rtl/stack_pkg.sv
// Shared constants and enumerations for the operand stack.
package stack_pkg;

   localparam int unsigned DEF_DATA_LEN = 8;
   localparam int unsigned DEF_DEPTH    = 16;

   // Encoding matches the {push, pop} strobe pair.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } stack_op_t;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'b00,
      ST_PARTIAL = 2'b01,
      ST_FULL    = 2'b10
   } occ_t;

endpackage

// File: rtl/operand_stack_if.sv
// Strobe/data/status bundle between the arithmetic unit side and the operand stack.
interface operand_stack_if #(
   parameter int unsigned DATA_LEN = stack_pkg::DEF_DATA_LEN,
   parameter int unsigned DEPTH    = stack_pkg::DEF_DEPTH,
   parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
);
   logic                push;
   logic                pop;
   logic [DATA_LEN-1:0] data_in;
   logic [DATA_LEN-1:0] data_out;
   logic [CNT_W-1:0]    count;
   logic                empty;
   logic                full;
   logic                overflow;
   logic                underflow;

   modport master (
      output push, pop, data_in,
      input  data_out, count, empty, full, overflow, underflow
   );

   modport slave (
      input  push, pop, data_in,
      output data_out, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/stack_ram.sv
// DEPTH x DATA_LEN register file: one synchronous write port, one asynchronous read port.
module stack_ram #(
   parameter int unsigned DATA_LEN = stack_pkg::DEF_DATA_LEN,
   parameter int unsigned DEPTH    = stack_pkg::DEF_DEPTH,
   parameter int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [DATA_LEN-1:0] wdata,
   input  logic [AW-1:0]       raddr,
   output logic [DATA_LEN-1:0] rdata
);
   logic [DATA_LEN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/operand_stack.sv
// LIFO of operands with registered show-ahead top of stack, occupancy and sticky error flags.
module operand_stack
   import stack_pkg::*;
#(
   parameter int unsigned DATA_LEN = DEF_DATA_LEN,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input logic              clk,
   input logic              rstn,
   operand_stack_if.slave   bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic                push_s, pop_s;
   stack_op_t           op;
   logic [CNT_W-1:0]    count_q, count_nxt;
   logic [DATA_LEN-1:0] dout_q, dout_nxt;
   logic                ovf_q, ovf_nxt;
   logic                unf_q, unf_nxt;
   occ_t                occ_q, occ_nxt;
   logic                we;
   logic [AW-1:0]       waddr;
   logic [AW-1:0]       raddr;
   logic [DATA_LEN-1:0] rdata;

   // Floating (X/Z) strobes from an idle upstream unit count as inactive.
   assign push_s = (bus.push === 1'b1);
   assign pop_s  = (bus.pop === 1'b1);
   assign op     = stack_op_t'({push_s, pop_s});

   // Entry that becomes the new top after a pop.
   assign raddr = AW'(count_q - CNT_W'(2));

   stack_ram #(
      .DATA_LEN (DATA_LEN),
      .DEPTH    (DEPTH),
      .AW       (AW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (bus.data_in),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      count_nxt = count_q;
      dout_nxt  = dout_q;
      ovf_nxt   = ovf_q;
      unf_nxt   = unf_q;
      we        = 1'b0;
      waddr     = AW'(count_q);
      case (op)
         OP_PUSH: begin
            if (occ_q == ST_FULL) begin
               ovf_nxt = 1'b1;
            end else begin
               we        = 1'b1;
               count_nxt = count_q + CNT_W'(1);
               dout_nxt  = bus.data_in;
            end
         end
         OP_POP: begin
            if (occ_q == ST_EMPTY) begin
               unf_nxt = 1'b1;
            end else if (count_q == CNT_W'(1)) begin
               count_nxt = '0;
               dout_nxt  = '0;
            end else begin
               count_nxt = count_q - CNT_W'(1);
               dout_nxt  = rdata;
            end
         end
         OP_REPL: begin
            we       = 1'b1;
            dout_nxt = bus.data_in;
            if (occ_q == ST_EMPTY) begin
               count_nxt = CNT_W'(1);
               unf_nxt   = 1'b1;
            end else begin
               waddr = AW'(count_q - CNT_W'(1));
            end
         end
         default: ;
      endcase

      if (count_nxt == '0)                 occ_nxt = ST_EMPTY;
      else if (count_nxt == CNT_W'(DEPTH)) occ_nxt = ST_FULL;
      else                                 occ_nxt = ST_PARTIAL;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q <= '0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         occ_q   <= ST_EMPTY;
      end else begin
         count_q <= count_nxt;
         dout_q  <= dout_nxt;
         ovf_q   <= ovf_nxt;
         unf_q   <= unf_nxt;
         occ_q   <= occ_nxt;
      end
   end

   assign bus.data_out  = dout_q;
   assign bus.count     = count_q;
   assign bus.empty     = (occ_q == ST_EMPTY);
   assign bus.full      = (occ_q == ST_FULL);
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: directed table, corner sequences and randomized run against a queue model.
module tb_operand_stack;
   localparam int unsigned DL = 8;
   localparam int unsigned DP = 16;
   localparam int unsigned CW = 5;

   logic clk = 1'b0;
   logic rstn;

   operand_stack_if #(.DATA_LEN(DL), .DEPTH(DP), .CNT_W(CW)) bus ();

   operand_stack #(.DATA_LEN(DL), .DEPTH(DP), .CNT_W(CW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DL-1:0] mq [$];
   bit            m_ovf, m_unf;

   typedef struct {
      bit            r, p, q;
      logic [DL-1:0] d;
      logic [DL-1:0] dout;
      int            cnt;
      bit            e, f, ov, un;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Reference behaviour: a queue whose back is the top of stack.
   task automatic model(input bit r, input bit p, input bit q, input logic [DL-1:0] d);
      if (!r) begin
         mq.delete();
         m_ovf = 0;
         m_unf = 0;
      end else if (p && q) begin
         if (mq.size() == 0) begin
            mq.push_back(d);
            m_unf = 1;
         end else begin
            mq[mq.size()-1] = d;
         end
      end else if (p) begin
         if (mq.size() == DP) m_ovf = 1;
         else mq.push_back(d);
      end else if (q) begin
         if (mq.size() == 0) m_unf = 1;
         else void'(mq.pop_back());
      end
   endtask

   function automatic int model_top();
      return (mq.size() == 0) ? 0 : int'(mq[mq.size()-1]);
   endfunction

   task automatic step(input bit r, input bit p, input bit q, input logic [DL-1:0] d);
      rstn = r;
      bus.push = p;
      bus.pop = q;
      bus.data_in = d;
      model(r, p, q, d);
      @(posedge clk);
      #1;
   endtask

   // Idle strobes floated to Z, as the arithmetic unit does.
   task automatic step_z(input bit p, input bit q, input logic [DL-1:0] d);
      rstn = 1'b1;
      bus.push = p ? 1'b1 : 1'bz;
      bus.pop = q ? 1'b1 : 1'bz;
      bus.data_in = d;
      model(1'b1, p, q, d);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " count"}, int'(bus.count), mq.size());
      chk({tag, " data_out"}, int'(bus.data_out), model_top());
      chk({tag, " empty"}, int'(bus.empty), int'(mq.size() == 0));
      chk({tag, " full"}, int'(bus.full), int'(mq.size() == DP));
      chk({tag, " overflow"}, int'(bus.overflow), int'(m_ovf));
      chk({tag, " underflow"}, int'(bus.underflow), int'(m_unf));
   endtask

   initial begin
      logic [DL-1:0] prev;
      rstn = 1'b0;
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.data_in = '0;
      #2;

      // r p q din | dout cnt e f ov un
      tbl.push_back('{0, 0, 0, 8'd0,   8'd0,   0, 1, 0, 0, 0});
      tbl.push_back('{1, 1, 0, 8'd5,   8'd5,   1, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 0, 8'd7,   8'd7,   2, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 0, 8'd3,   8'd3,   3, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 8'd0,   8'd7,   2, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 8'd0,   8'd5,   1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 8'd0,   8'd0,   0, 1, 0, 0, 0});
      tbl.push_back('{1, 1, 0, 8'd4,   8'd4,   1, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 0, 8'd9,   8'd9,   2, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 1, 8'hFE,  8'hFE,  2, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 8'd0,   8'd4,   1, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 8'd0,   8'd0,   0, 1, 0, 0, 0});
      tbl.push_back('{1, 1, 1, 8'd6,   8'd6,   1, 0, 0, 0, 1});
      tbl.push_back('{0, 1, 1, 8'd0,   8'd0,   0, 1, 0, 0, 0});

      prev = '0;
      foreach (tbl[i]) begin
         if (tbl[i].q && !tbl[i].p && i > 0)
            chk($sformatf("tbl%0d pop_sample", i), int'(bus.data_out), int'(prev));
         step(tbl[i].r, tbl[i].p, tbl[i].q, tbl[i].d);
         chk($sformatf("tbl%0d data_out", i), int'(bus.data_out), int'(tbl[i].dout));
         chk($sformatf("tbl%0d count", i), int'(bus.count), tbl[i].cnt);
         chk($sformatf("tbl%0d empty", i), int'(bus.empty), int'(tbl[i].e));
         chk($sformatf("tbl%0d full", i), int'(bus.full), int'(tbl[i].f));
         chk($sformatf("tbl%0d overflow", i), int'(bus.overflow), int'(tbl[i].ov));
         chk($sformatf("tbl%0d underflow", i), int'(bus.underflow), int'(tbl[i].un));
         prev = tbl[i].dout;
      end

      // Fill to capacity, then overflow.
      step(0, 0, 0, 8'd0);
      for (int v = 1; v <= DP; v++) step(1, 1, 0, DL'(v));
      chk("fill full", int'(bus.full), 1);
      chk("fill count", int'(bus.count), DP);
      step(1, 1, 0, 8'd99);
      chk("ovf flag", int'(bus.overflow), 1);
      chk("ovf count", int'(bus.count), DP);
      chk("ovf data_out", int'(bus.data_out), 16);
      step(1, 0, 1, 8'd0);
      chk("ovf pop data_out", int'(bus.data_out), 15);
      check_model("fill");

      // Underflow is sticky until reset.
      step(0, 0, 0, 8'd0);
      step(1, 0, 1, 8'd0);
      chk("unf flag", int'(bus.underflow), 1);
      chk("unf count", int'(bus.count), 0);
      chk("unf data_out", int'(bus.data_out), 0);
      for (int k = 0; k < 10; k++) step(1, 0, 0, 8'd0);
      chk("unf sticky", int'(bus.underflow), 1);
      step(0, 0, 0, 8'd0);
      chk("unf cleared", int'(bus.underflow), 0);

      // Arithmetic-unit style traffic with floating strobes.
      step(1, 1, 0, 8'd10);
      step(1, 1, 0, 8'd3);
      chk("au operand a", int'(bus.data_out), 3);
      step_z(0, 1, 8'd0);
      step_z(0, 0, 8'd0);
      chk("au operand b", int'(bus.data_out), 10);
      step_z(0, 1, 8'd0);
      step_z(1, 0, 8'd13);
      chk("au count", int'(bus.count), 1);
      chk("au data_out", int'(bus.data_out), 13);
      chk("au flags", int'({bus.overflow, bus.underflow}), 0);
      step(1, 0, 0, 8'd0);
      check_model("au");

      // Reset overrides a concurrent push.
      step(1, 1, 0, 8'd21);
      step(1, 0, 1, 8'd0);
      step(1, 0, 1, 8'd0);
      step(0, 1, 0, 8'd8);
      chk("rst count", int'(bus.count), 0);
      chk("rst data_out", int'(bus.data_out), 0);
      chk("rst empty", int'(bus.empty), 1);
      chk("rst flags", int'({bus.overflow, bus.underflow}), 0);
      check_model("rst");

      // Randomized traffic; phases bias toward filling or draining.
      for (int i = 0; i < 3000; i++) begin
         bit r, p, q;
         int bias;
         bias = ((i / 150) % 2 == 1) ? 75 : 25;
         r = ($urandom_range(0, 199) != 0);
         p = ($urandom_range(0, 99) < bias);
         q = ($urandom_range(0, 99) < (100 - bias));
         step(r, p, q, DL'($urandom));
         check_model($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
